// File: rtl/oc8051_ram_bist_ctrl.sv
// oc8051_ram_bist_ctrl: March C- self-test initiator for the oc8051 internal RAM.
// Port 0 issues the reads. Port 1 issues the writes. Reads and writes never hit
// the same address in the same cycle.
// Optional diagnostics (fail_exp, fail_act, err_cnt) are enabled by OC8051_BIST_DIAG_EN.
module oc8051_ram_bist_ctrl #(
  parameter int ADR_WIDTH  = 6,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] BG = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADR_WIDTH-1:0]  fail_adr,
  output logic [2:0]            fail_elem,
`ifdef OC8051_BIST_DIAG_EN
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_act,
  output logic [7:0]            err_cnt,
`endif
  output logic [ADR_WIDTH-1:0]  ram_adr0,
  output logic                  ram_en0,
  input  logic [DATA_WIDTH-1:0] ram_dat0_i,
  output logic [ADR_WIDTH-1:0]  ram_adr1,
  output logic [DATA_WIDTH-1:0] ram_dat1_o,
  output logic                  ram_en1,
  output logic                  ram_wr1
);

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_CHK, DONE} state_t;

  localparam logic [ADR_WIDTH-1:0] ADR_MAX = '1;

  state_t                  state, state_nxt;
  logic [ADR_WIDTH-1:0]    adr, adr_nxt;
  logic [2:0]              elem, elem_nxt, elem_inc;
  logic                    run_start, chk_en, last_adr, miscmp;
  logic [DATA_WIDTH-1:0]   exp_dat;

  // Elements 3 and 4 sweep downward; all others sweep upward.
  function automatic logic elem_down(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  // Elements 2 and 4 read the complement pattern; the others read the background.
  function automatic logic [DATA_WIDTH-1:0] elem_rd_val(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? ~BG : BG;
  endfunction

  // The error counter saturates instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  assign exp_dat  = elem_rd_val(elem);
  assign elem_inc = elem + 3'd1;
  assign last_adr = elem_down(elem) ? (adr == '0) : (adr == ADR_MAX);
  assign miscmp   = chk_en && (ram_dat0_i != exp_dat);

  // Next-state, sweep counters and RAM port drive.
  always_comb begin
    state_nxt  = state;
    adr_nxt    = adr;
    elem_nxt   = elem;
    run_start  = 1'b0;
    chk_en     = 1'b0;
    busy       = 1'b0;
    ram_adr0   = '0;
    ram_en0    = 1'b0;
    ram_adr1   = '0;
    ram_dat1_o = '0;
    ram_en1    = 1'b0;
    ram_wr1    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start && !abort) begin
          state_nxt = WR;
          adr_nxt   = '0;
          elem_nxt  = 3'd0;
          run_start = 1'b1;
        end
      end
      WR: begin
        busy       = 1'b1;
        ram_en1    = 1'b1;
        ram_wr1    = 1'b1;
        ram_adr1   = adr;
        ram_dat1_o = BG;
        if (abort) begin
          state_nxt = IDLE;
        end else if (last_adr) begin
          state_nxt = RD_ISSUE;
          elem_nxt  = 3'd1;
          adr_nxt   = '0;
        end else begin
          adr_nxt = adr + 1'b1;
        end
      end
      RD_ISSUE: begin
        busy     = 1'b1;
        ram_en0  = 1'b1;
        ram_adr0 = adr;
        state_nxt = abort ? IDLE : RD_CHK;
      end
      RD_CHK: begin
        busy   = 1'b1;
        chk_en = 1'b1;
        if (elem != 3'd5) begin
          ram_en1    = 1'b1;
          ram_wr1    = 1'b1;
          ram_adr1   = adr;
          ram_dat1_o = ~exp_dat;
        end
        if (abort) begin
          state_nxt = IDLE;
        end else if (last_adr) begin
          if (elem == 3'd5) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RD_ISSUE;
            elem_nxt  = elem_inc;
            adr_nxt   = elem_down(elem_inc) ? ADR_MAX : '0;
          end
        end else begin
          state_nxt = RD_ISSUE;
          adr_nxt   = elem_down(elem) ? adr - 1'b1 : adr + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, address and element registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      adr   <= '0;
      elem  <= 3'd0;
    end else begin
      state <= state_nxt;
      adr   <= adr_nxt;
      elem  <= elem_nxt;
    end
  end

  // Sticky result flags; only the first miscompare records its location.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_adr  <= '0;
      fail_elem <= 3'd0;
`ifdef OC8051_BIST_DIAG_EN
      fail_exp  <= '0;
      fail_act  <= '0;
      err_cnt   <= 8'd0;
`endif
    end else if (run_start) begin
      done      <= 1'b0;
      fail      <= 1'b0;
      fail_adr  <= '0;
      fail_elem <= 3'd0;
`ifdef OC8051_BIST_DIAG_EN
      fail_exp  <= '0;
      fail_act  <= '0;
      err_cnt   <= 8'd0;
`endif
    end else begin
      if ((state == RD_CHK) && (state_nxt == DONE))
        done <= 1'b1;
      if (miscmp) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_adr  <= adr;
          fail_elem <= elem;
`ifdef OC8051_BIST_DIAG_EN
          fail_exp  <= exp_dat;
          fail_act  <= ram_dat0_i;
`endif
        end
`ifdef OC8051_BIST_DIAG_EN
        err_cnt <= sat_inc(err_cnt);
`endif
      end
    end
  end

endmodule

// File: tb/tb_oc8051_ram_bist_ctrl.sv
// Bench for oc8051_ram_bist_ctrl: behavioural RAM with injectable faults and
// a scoreboard of the expected March C- port transaction sequence.
module tb_oc8051_ram_bist_ctrl;

  typedef struct packed {
    logic       we;
    logic [5:0] adr;
    logic [7:0] dat;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic       busy, done, fail;
  logic [5:0] fail_adr;
  logic [2:0] fail_elem;
`ifdef OC8051_BIST_DIAG_EN
  logic [7:0] fail_exp, fail_act, err_cnt;
`endif
  logic [5:0] ram_adr0, ram_adr1;
  logic       ram_en0, ram_en1, ram_wr1;
  logic [7:0] ram_dat0_i, ram_dat1_o;

  logic [7:0] mem [64];
  int         fault = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         cnt_wr = 0;
  int         cnt_rd = 0;
  ev_t        sb[$];

  oc8051_ram_bist_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_adr   (fail_adr),
    .fail_elem  (fail_elem),
`ifdef OC8051_BIST_DIAG_EN
    .fail_exp   (fail_exp),
    .fail_act   (fail_act),
    .err_cnt    (err_cnt),
`endif
    .ram_adr0   (ram_adr0),
    .ram_en0    (ram_en0),
    .ram_dat0_i (ram_dat0_i),
    .ram_adr1   (ram_adr1),
    .ram_dat1_o (ram_dat1_o),
    .ram_en1    (ram_en1),
    .ram_wr1    (ram_wr1)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: registered port-0 read, port-1 write, optional faults.
  always @(posedge clk) begin
    if (ram_en0)
      ram_dat0_i <= mem[ram_adr0] | ((fault == 1 && ram_adr0 == 6'd5) ? 8'h01 : 8'h00);
    if (ram_en1 && ram_wr1) begin
      mem[ram_adr1] <= ram_dat1_o;
      if (fault == 2 && ram_adr1 == 6'd10 && ram_dat1_o == 8'hFF)
        mem[11] <= 8'hFF;
    end
  end

  // Every RAM access is checked in order against the expected March sequence.
  always @(negedge clk) begin
    if (ram_en0 || ram_wr1) begin
      ev_t obs, e;
      obs = '{we: ram_wr1, adr: (ram_en0 ? ram_adr0 : ram_adr1),
              dat: (ram_wr1 ? ram_dat1_o : 8'h00)};
      if (ram_en0) cnt_rd++;
      if (ram_wr1) cnt_wr++;
      vectors++;
      if (sb.size() == 0) begin
        e = '0;
        assert (1'b0) else begin
          miscompares++;
          $error("FAIL sb_empty observed=%h expected=none", obs);
        end
      end else begin
        e = sb.pop_front();
        assert (obs === e && !(ram_en0 && ram_wr1)) else begin
          miscompares++;
          $error("FAIL ram_seq cyc=%0d observed=%h expected=%h", cyc, obs, e);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push_march();
    logic [5:0] a;
    for (int i = 0; i < 64; i++) sb.push_back('{we: 1'b1, adr: 6'(i), dat: 8'h00});
    for (int e = 1; e <= 4; e++) begin
      for (int i = 0; i < 64; i++) begin
        a = (e == 3 || e == 4) ? 6'(63 - i) : 6'(i);
        sb.push_back('{we: 1'b0, adr: a, dat: 8'h00});
        sb.push_back('{we: 1'b1, adr: a, dat: ((e % 2) == 1) ? 8'hFF : 8'h00});
      end
    end
    for (int i = 0; i < 64; i++) sb.push_back('{we: 1'b0, adr: 6'(i), dat: 8'h00});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // start is high during cycle 0; returns at cycle 1.
  task automatic begin_run();
    start  = 1'b1;
    cyc    = 0;
    cnt_wr = 0;
    cnt_rd = 0;
    push_march();
    step();
    start = 1'b0;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic chk_ports_idle(input string tag);
    chk(tag, {ram_en0, ram_en1, ram_wr1, ram_adr0, ram_adr1, ram_dat1_o}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_status", {busy, done, fail, fail_adr, fail_elem}, 32'h0);
    chk_ports_idle("rst_ports");
    rst = 1'b0;
    step();

    // Clean run with an ignored start pulse mid-run.
    fault = 0;
    begin_run();
    chk("run1_busy_c1", {busy, done}, 32'h2);
    run_to(300);
    start = 1'b1;
    step();
    start = 1'b0;
    run_to(704);
    chk("run1_busy_c704", {busy, done}, 32'h2);
    step();
    chk("run1_done_c705", {busy, done, fail}, 32'h2);
    chk_ports_idle("run1_ports_done");
    chk("run1_writes", cnt_wr, 320);
    chk("run1_reads", cnt_rd, 320);
    chk("run1_sb_drained", sb.size(), 0);

    // Bit 0 of address 5 stuck at 1.
    fault = 1;
    begin_run();
    chk("run2_cleared_c1", {busy, done, fail}, 32'h4);
    run_to(705);
    chk("run2_status", {busy, done, fail}, 32'h3);
    chk("run2_fail_adr", fail_adr, 5);
    chk("run2_fail_elem", fail_elem, 1);
`ifdef OC8051_BIST_DIAG_EN
    chk("run2_fail_exp", fail_exp, 8'h00);
    chk("run2_fail_act", fail_act, 8'h01);
    chk("run2_err_cnt", err_cnt, 3);
`endif

    // Writing 8'hFF to address 10 also forces address 11 to 8'hFF.
    fault = 2;
    begin_run();
    chk("run3_fail_clear_c1", fail, 0);
    run_to(704);
    chk("run3_busy_c704", {busy, done}, 32'h2);
    step();
    chk("run3_status", {busy, done, fail}, 32'h3);
    chk("run3_fail_adr", fail_adr, 11);
    chk("run3_fail_elem", fail_elem, 1);
`ifdef OC8051_BIST_DIAG_EN
    chk("run3_fail_act", fail_act, 8'hFF);
    chk("run3_err_cnt", err_cnt, 1);
`endif

    // Abort at cycle 200, then a clean full run.
    fault = 0;
    begin_run();
    run_to(200);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_status", {busy, done, fail}, 32'h0);
    chk_ports_idle("abort_ports");
    sb.delete();
    step();
    step();
    chk("abort_stays_idle", {busy, done}, 32'h0);
    begin_run();
    run_to(705);
    chk("run4_status", {busy, done, fail}, 32'h2);
    chk("run4_writes", cnt_wr, 320);
    chk("run4_reads", cnt_rd, 320);

    // Reset mid-run after a miscompare has been recorded.
    fault = 1;
    begin_run();
    run_to(400);
    chk("run5_fail_before_rst", {busy, fail, fail_adr}, {24'h0, 2'b11, 6'd5});
    rst = 1'b1;
    #1;
    chk("rst_mid_status", {busy, done, fail, fail_adr, fail_elem}, 32'h0);
    chk_ports_idle("rst_mid_ports");
    sb.delete();
    step();
    rst = 1'b0;
    step();

    // abort outranks start in IDLE.
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_over_start", {busy, done}, 32'h0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/oc8051_ram_bist_ctrl.md
Name: oc8051_ram_bist_ctrl

Overview:
March C- built-in self-test initiator for the oc8051 dual-port internal RAM. Drives the RAM read port (port 0) and read/write port (port 1) through a full address sweep and compares read data against expected background patterns. Reports pass/fail plus first-failure location. Sits beside the RAM; its outputs are muxed onto the RAM ports while busy is high.

Parameters:
ADR_WIDTH, 6, RAM address width; depth N = 2**ADR_WIDTH
DATA_WIDTH, 8, RAM word width
BG, 8'h00, background data pattern; the complement ~BG is the "1" pattern

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; begins test when in IDLE
abort  in  1  synchronous abort; returns to IDLE without setting done
busy  out  1  test in progress
done  out  1  sticky; test completed normally
fail  out  1  sticky; at least one miscompare
fail_adr  out  ADR_WIDTH  address of first miscompare
fail_elem  out  3  March element index of first miscompare (0..5)
ram_adr0  out  ADR_WIDTH  port-0 read address
ram_en0  out  1  port-0 read enable
ram_dat0_i  in  DATA_WIDTH  port-0 read data; registered, valid 1 cycle after ram_en0
ram_adr1  out  ADR_WIDTH  port-1 address
ram_dat1_o  out  DATA_WIDTH  port-1 write data
ram_en1  out  1  port-1 enable
ram_wr1  out  1  port-1 write strobe

Behaviour:
- Reset: state IDLE; busy=0, done=0, fail=0, fail_adr=0, fail_elem=0; all ram_* outputs 0.
- Elements: E0 up(w BG); E1 up(r BG, w ~BG); E2 up(r ~BG, w BG); E3 down(r BG, w ~BG); E4 down(r ~BG, w BG); E5 up(r BG). "up" sweeps 0..N-1; "down" sweeps N-1..0.
- States: IDLE, WR (E0), RD_ISSUE, RD_CHK, DONE.
- IDLE: start=1 at cycle 0 -> WR at cycle 1; clears done, fail and fail_* regs; busy=1 from cycle 1.
- WR: one address per cycle. ram_en1=1, ram_wr1=1, ram_dat1_o=BG. After address N-1 -> RD_ISSUE of E1.
- RD_ISSUE: ram_en0=1, ram_adr0=current address; no write.
- RD_CHK: compare ram_dat0_i with the expected value. In E1..E4, the same cycle writes the element's write value to the same address (ram_en1=ram_wr1=1). Then advance address -> RD_ISSUE. After the last address, go to the next element. After E5, go to DONE.
- Cycle count: E0=N, E1..E5=2N each; N=64 gives 704 active cycles. busy=1 for cycles 1..704. done=1 and busy=0 from cycle 705.
- Address counter: ADR_WIDTH bits; the end test is ==N-1 (up) or ==0 (down). No wrap beyond one sweep.
- Miscompare: fail=1. The first miscompare only latches fail_adr and fail_elem; later miscompares do not update them. The test always runs to completion.
- DONE: ram_* all 0; holds done and fail. start -> new run, same as from IDLE.
- start while busy: ignored.
- abort (any busy state): next cycle IDLE, busy=0, ram_* 0. done stays 0; fail and fail_* keep their values.
- abort has priority over start.
- rst mid-run: immediate return to reset values. RAM contents are undefined afterwards.
- ram_en0 and ram_wr1 are never high to the same address in the same cycle, so the RAM read-during-write bypass is never exercised.

Optional Feature:
OC8051_BIST_DIAG_EN: adds outputs fail_exp (DATA_WIDTH), fail_act (DATA_WIDTH) and err_cnt (8).
- fail_exp/fail_act: expected and actual data of the first miscompare.
- err_cnt: counts all miscompares, saturates at 8'hFF, cleared on start and rst.
- Without the macro: these ports and registers are absent; behaviour is otherwise identical.

Test Plan:
- Fault-free behavioural RAM, start at cycle 0 -> busy cycles 1..704, done=1 at 705, fail=0. Exactly 320 writes (ram_wr1 pulses) and 320 reads.
- RAM with bit0 of address 5 stuck-at-1 -> fail=1, fail_adr=5, fail_elem=1. DIAG: fail_exp=8'h00, fail_act=8'h01, err_cnt=3 (E1, E3, E5).
- Coupling fault: a write of ~BG to address 10 forces address 11 to 8'hFF -> fail_adr=11, fail_elem=1, done at cycle 705.
- abort at cycle 200 -> busy=0 at 201, done=0, ram_* 0. Then start -> clean full run passes.
- start pulsed at cycle 300 during a run -> ignored, done still at 705. rst at cycle 400 -> all outputs at reset values immediately.
- Monitor on every cycle: ram_adr0 and ram_adr1 stay within 0..63. E3/E4 sweep addresses in descending order.
